// File: rtl/motor_drive.sv
// motor_drive: dual-channel L298-style H-bridge driver.
// Each channel soft-starts its PWM duty from 0 to DUTY_MAX and holds the bridge
// off for DEAD_CYCLES whenever a running motor is commanded to reverse.
// Optional build macro: MOTOR_DRIVE_BRAKE_EN makes STOP/DEAD drive an active
// short-brake (pair = 11, enable = 1) instead of coasting.
// Channel index 1 = motor A (motorIn[3:2]), index 0 = motor B (motorIn[1:0]).
module motor_drive #(
   parameter int unsigned PWM_BITS    = 8,
   parameter int unsigned DUTY_MAX    = 200,
   parameter int unsigned RAMP_STEP   = 4,
   parameter int unsigned RAMP_DIV    = 500,
   parameter int unsigned DEAD_CYCLES = 1000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] motorIn,
   input  logic [1:0] motorEn,
   output logic [3:0] hb_in,
   output logic [1:0] hb_en,
   output logic [1:0] dead_active,
   output logic [1:0] at_speed
);

   localparam int unsigned TMAX = (RAMP_DIV > DEAD_CYCLES) ? RAMP_DIV : DEAD_CYCLES;
   localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
   localparam int unsigned DW   = PWM_BITS + 1;

   localparam logic [PWM_BITS-1:0] DUTY_MAX_W = PWM_BITS'(DUTY_MAX);
   localparam logic [DW-1:0]       STEP_W     = DW'(RAMP_STEP);
   localparam logic [TW-1:0]       RAMP_LAST  = TW'(RAMP_DIV - 1);
   localparam logic [TW-1:0]       DEAD_LAST  = TW'(DEAD_CYCLES - 1);

`ifdef MOTOR_DRIVE_BRAKE_EN
   localparam logic [1:0] IDLE_PAIR = 2'b11;
   localparam logic       IDLE_EN   = 1'b1;
`else
   localparam logic [1:0] IDLE_PAIR = 2'b00;
   localparam logic       IDLE_EN   = 1'b0;
`endif

   typedef enum logic [1:0] {
      ST_STOP,
      ST_RAMP,
      ST_RUN,
      ST_DEAD
   } state_e;

   state_e              state_q [2];
   state_e              state_d [2];
   logic [PWM_BITS-1:0] duty_q  [2];
   logic [PWM_BITS-1:0] duty_d  [2];
   logic [1:0]          dir_q   [2];
   logic [1:0]          dir_d   [2];
   logic [TW-1:0]       tmr_q   [2];
   logic [TW-1:0]       tmr_d   [2];
   logic [1:0]          cmd     [2];
   logic [DW-1:0]       ramp_sum[2];
   logic [1:0]          go;

   logic [PWM_BITS-1:0] pwm_q;
   logic [3:0]          hb_in_q, hb_in_d;
   logic [1:0]          hb_en_q, hb_en_d;
   logic [1:0]          dead_q, dead_d;
   logic [1:0]          at_speed_q, at_speed_d;

   // Decode per-channel command: direction pair, "go" qualifier and next ramp duty.
   always_comb begin
      go = '0;
      for (int unsigned ch = 0; ch < 2; ch++) begin
         cmd[ch]      = motorIn[ch*2 +: 2];
         go[ch]       = motorEn[ch] && (cmd[ch] == 2'b10 || cmd[ch] == 2'b01);
         ramp_sum[ch] = {1'b0, duty_q[ch]} + STEP_W;
      end
   end

   // Channel state machines: next state, duty, latched direction and shared ramp/dead timer.
   always_comb begin
      for (int unsigned ch = 0; ch < 2; ch++) begin
         state_d[ch] = state_q[ch];
         duty_d[ch]  = duty_q[ch];
         dir_d[ch]   = dir_q[ch];
         tmr_d[ch]   = tmr_q[ch];
         unique case (state_q[ch])
            ST_STOP: begin
               duty_d[ch] = '0;
               if (go[ch]) begin
                  dir_d[ch]   = cmd[ch];
                  tmr_d[ch]   = '0;
                  state_d[ch] = ST_RAMP;
               end
            end
            ST_RAMP, ST_RUN: begin
               if (!go[ch]) begin
                  duty_d[ch]  = '0;
                  state_d[ch] = ST_STOP;
               end else if (cmd[ch] != dir_q[ch]) begin
                  duty_d[ch]  = '0;
                  tmr_d[ch]   = '0;
                  state_d[ch] = ST_DEAD;
               end else if (state_q[ch] == ST_RUN) begin
                  duty_d[ch] = DUTY_MAX_W;
               end else if (duty_q[ch] >= DUTY_MAX_W) begin
                  state_d[ch] = ST_RUN;
               end else if (tmr_q[ch] == RAMP_LAST) begin
                  tmr_d[ch] = '0;
                  // Sum is one bit wider than duty so a large step cannot wrap past DUTY_MAX.
                  if (ramp_sum[ch] >= {1'b0, DUTY_MAX_W}) begin
                     duty_d[ch]  = DUTY_MAX_W;
                     state_d[ch] = ST_RUN;
                  end else begin
                     duty_d[ch] = ramp_sum[ch][PWM_BITS-1:0];
                  end
               end else begin
                  tmr_d[ch] = tmr_q[ch] + 1'b1;
               end
            end
            ST_DEAD: begin
               duty_d[ch] = '0;
               if (!go[ch]) begin
                  state_d[ch] = ST_STOP;
               end else if (tmr_q[ch] == DEAD_LAST) begin
                  dir_d[ch]   = cmd[ch];
                  tmr_d[ch]   = '0;
                  state_d[ch] = ST_RAMP;
               end else begin
                  tmr_d[ch] = tmr_q[ch] + 1'b1;
               end
            end
            default: begin
               duty_d[ch]  = '0;
               state_d[ch] = ST_STOP;
            end
         endcase
      end
   end

   // Bridge pin values derived from current state; registered below for glitch-free pins.
   always_comb begin
      hb_in_d    = '0;
      hb_en_d    = '0;
      dead_d     = '0;
      at_speed_d = '0;
      for (int unsigned ch = 0; ch < 2; ch++) begin
         unique case (state_q[ch])
            ST_RAMP, ST_RUN: begin
               hb_in_d[ch*2 +: 2] = dir_q[ch];
               hb_en_d[ch]        = (pwm_q < duty_q[ch]);
               at_speed_d[ch]     = (state_q[ch] == ST_RUN);
            end
            ST_DEAD: begin
               hb_in_d[ch*2 +: 2] = IDLE_PAIR;
               hb_en_d[ch]        = IDLE_EN;
               dead_d[ch]         = 1'b1;
            end
            default: begin
               hb_in_d[ch*2 +: 2] = IDLE_PAIR;
               hb_en_d[ch]        = IDLE_EN;
            end
         endcase
      end
   end

   // State, timer, PWM counter and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned ch = 0; ch < 2; ch++) begin
            state_q[ch] <= ST_STOP;
            duty_q[ch]  <= '0;
            dir_q[ch]   <= '0;
            tmr_q[ch]   <= '0;
         end
         pwm_q      <= '0;
         hb_in_q    <= '0;
         hb_en_q    <= '0;
         dead_q     <= '0;
         at_speed_q <= '0;
      end else begin
         for (int unsigned ch = 0; ch < 2; ch++) begin
            state_q[ch] <= state_d[ch];
            duty_q[ch]  <= duty_d[ch];
            dir_q[ch]   <= dir_d[ch];
            tmr_q[ch]   <= tmr_d[ch];
         end
         pwm_q      <= pwm_q + 1'b1;
         hb_in_q    <= hb_in_d;
         hb_en_q    <= hb_en_d;
         dead_q     <= dead_d;
         at_speed_q <= at_speed_d;
      end
   end

   assign hb_in       = hb_in_q;
   assign hb_en       = hb_en_q;
   assign dead_active = dead_q;
   assign at_speed    = at_speed_q;

endmodule
